// File: rtl/freq_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : freq_gen                                                        |
// | Purpose  : Programmable 50% duty square-wave generator, period = 2*H clks. |
// |            New H values are applied glitch-free at the 1->0 boundary.      |
// | Options  : FREQ_GEN_BURST_EN adds burst_len/burst_done and a DONE state.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module freq_gen #(
  parameter int DIV_W    = 24,
  parameter int DEF_HALF = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
`ifdef FREQ_GEN_BURST_EN
  input  logic [15:0]      burst_len,
  output logic             burst_done,
`endif
  output logic             load_ack,
  output logic             signal,
  output logic             running
);

  localparam logic [DIV_W-1:0] c_ONE      = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] c_DEF_HALF = DIV_W'(DEF_HALF);

`ifdef FREQ_GEN_BURST_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_v;
  logic             r_signal;
  logic             r_load_ack;
  logic             r_running;
`ifdef FREQ_GEN_BURST_EN
  logic [15:0]      r_burst_len;
  logic [15:0]      r_burst_cnt;
  logic             r_burst_done;
  logic             w_last_period;
`endif

  logic [DIV_W-1:0] w_half_clamp;
  logic [DIV_W-1:0] w_clamp_m1;
  logic [DIV_W-1:0] w_active_m1;
  logic [DIV_W-1:0] w_pend_m1;

  // A requested half-period of zero would never toggle; treat it as one.
  assign w_half_clamp = (half_period == '0) ? c_ONE : half_period;
  assign w_clamp_m1   = w_half_clamp - c_ONE;
  assign w_active_m1  = r_active - c_ONE;
  assign w_pend_m1    = r_pend - c_ONE;

`ifdef FREQ_GEN_BURST_EN
  assign w_last_period = (r_burst_len != 16'd0) &&
                         (r_burst_cnt == (r_burst_len - 16'd1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_active     <= c_DEF_HALF;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_signal     <= 1'b0;
      r_load_ack   <= 1'b0;
      r_running    <= 1'b0;
`ifdef FREQ_GEN_BURST_EN
      r_burst_len  <= '0;
      r_burst_cnt  <= '0;
      r_burst_done <= 1'b0;
`endif
    end else begin
      r_load_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_signal <= 1'b0;
          r_cnt    <= '0;
          if (load) begin
            r_active   <= w_half_clamp;
            r_load_ack <= 1'b1;
          end
          if (en) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_cnt     <= load ? w_clamp_m1 : w_active_m1;
`ifdef FREQ_GEN_BURST_EN
            r_burst_len <= burst_len;
            r_burst_cnt <= '0;
`endif
          end
        end

        S_RUN: begin
          if (!en) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_signal  <= 1'b0;
            r_cnt     <= '0;
            r_pend_v  <= 1'b0;
            if (load) begin
              r_active   <= w_half_clamp;
              r_load_ack <= 1'b1;
            end else if (r_pend_v) begin
              r_active   <= r_pend;
              r_load_ack <= 1'b1;
            end
          end else begin
            if (load) begin
              r_pend   <= w_half_clamp;
              r_pend_v <= 1'b1;
            end
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_ONE;
            end else begin
              r_signal <= ~r_signal;
              // Only the falling toggle is a period boundary for new H values.
              if (r_signal && r_pend_v) begin
                r_active   <= r_pend;
                r_cnt      <= w_pend_m1;
                r_load_ack <= 1'b1;
                if (!load) begin
                  r_pend_v <= 1'b0;
                end
              end else begin
                r_cnt <= w_active_m1;
              end
`ifdef FREQ_GEN_BURST_EN
              if (r_signal) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
                if (w_last_period) begin
                  r_state      <= S_DONE;
                  r_running    <= 1'b0;
                  r_burst_done <= 1'b1;
                  r_cnt        <= '0;
                end
              end
`endif
            end
          end
        end

`ifdef FREQ_GEN_BURST_EN
        S_DONE: begin
          r_signal <= 1'b0;
          r_cnt    <= '0;
          if (load) begin
            r_active   <= w_half_clamp;
            r_load_ack <= 1'b1;
            r_pend_v   <= 1'b0;
          end else if (r_pend_v) begin
            r_active   <= r_pend;
            r_load_ack <= 1'b1;
            r_pend_v   <= 1'b0;
          end
          if (!en) begin
            r_state      <= S_IDLE;
            r_burst_done <= 1'b0;
          end
        end
`endif

        default: begin
          r_state   <= S_IDLE;
          r_signal  <= 1'b0;
          r_running <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign signal   = r_signal;
  assign load_ack = r_load_ack;
  assign running  = r_running;
`ifdef FREQ_GEN_BURST_EN
  assign burst_done = r_burst_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_freq_gen.sv
// Directed testbench for freq_gen: reset, default period, loads in IDLE/RUN,
// clamp/overwrite, boundary-coincident load, stop with pending value, burst.
`timescale 1ns/1ps
`default_nettype none

module tb_freq_gen;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [DIV_W-1:0] half_period;
  logic             load_ack;
  logic             sig;
  logic             running;
`ifdef FREQ_GEN_BURST_EN
  logic [15:0]      burst_len;
  logic             burst_done;
`endif

  int checks = 0;
  int errors = 0;

  freq_gen #(.DIV_W(DIV_W), .DEF_HALF(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .half_period(half_period),
`ifdef FREQ_GEN_BURST_EN
    .burst_len  (burst_len),
    .burst_done (burst_done),
`endif
    .load_ack   (load_ack),
    .signal     (sig),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges until signal reaches val (bounded at 500).
  task automatic cycles_until(input logic val, output int n);
    n = 0;
    while (sig !== val && n < 500) begin
      step();
      n++;
    end
  endtask

  task automatic load_idle(input logic [DIV_W-1:0] h);
    half_period = h;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  task automatic start_run();
    en = 1'b1;
    step();
  endtask

  task automatic stop_run();
    en = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; half_period = '0;
`ifdef FREQ_GEN_BURST_EN
    burst_len = 16'd0;
`endif
    #3;
    checks++; if (sig !== 1'b0) begin errors++; $display("FAIL reset_signal: got %b want 0", sig); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", load_ack); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checks++; if (running !== 1'b0 || sig !== 1'b0) begin errors++; $display("FAIL reset_idle: got run=%b sig=%b want 0 0", running, sig); end
  endtask

  task automatic test_default();
    int n;
    start_run();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL default_running: got %b want 1", running); end
    cycles_until(1'b1, n);
    checks++; if (n !== 50) begin errors++; $display("FAIL default_first_rise: got %0d want 50", n); end
    cycles_until(1'b0, n);
    checks++; if (n !== 50) begin errors++; $display("FAIL default_high: got %0d want 50", n); end
    cycles_until(1'b1, n);
    checks++; if (n !== 50) begin errors++; $display("FAIL default_low: got %0d want 50", n); end
    stop_run();
  endtask

  task automatic test_load_idle();
    int n;
    half_period = 3; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL idle_ack: got %b want 1", load_ack); end
    step();
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL idle_ack_pulse: got %b want 0", load_ack); end
    start_run();
    cycles_until(1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL idle_first_rise: got %0d want 3", n); end
    cycles_until(1'b0, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL idle_high: got %0d want 3", n); end
    cycles_until(1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL idle_low: got %0d want 3", n); end
    en = 1'b0;
    step();
    checks++; if (sig !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL stop: got sig=%b run=%b want 0 0", sig, running); end
    step();
  endtask

  task automatic test_live_change();
    int n;
    load_idle(5);
    start_run();
    cycles_until(1'b1, n);
    half_period = 2; load = 1'b1;
    step();
    load = 1'b0;
    cycles_until(1'b0, n);
    checks++; if (n + 1 !== 5) begin errors++; $display("FAIL live_high_kept: got %0d want 5", n + 1); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL live_ack_at_fall: got %b want 1", load_ack); end
    step();
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL live_ack_pulse: got %b want 0", load_ack); end
    cycles_until(1'b1, n);
    checks++; if (n + 1 !== 2) begin errors++; $display("FAIL live_new_low: got %0d want 2", n + 1); end
    cycles_until(1'b0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL live_new_high: got %0d want 2", n); end
    stop_run();
  endtask

  task automatic test_clamp_overwrite();
    int n;
    int acks;
    load_idle(2);
    start_run();
    cycles_until(1'b1, n);
    cycles_until(1'b0, n);
    half_period = 0; load = 1'b1;
    step();
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL ovw_no_early_ack: got %b want 0", load_ack); end
    half_period = 7;
    step();
    load = 1'b0;
    acks = 0;
    n = 0;
    while (sig !== 1'b0 && n < 500) begin step(); n++; if (load_ack === 1'b1) acks++; end
    checks++; if (n !== 2) begin errors++; $display("FAIL ovw_old_high: got %0d want 2", n); end
    n = 0;
    while (sig !== 1'b1 && n < 500) begin step(); n++; if (load_ack === 1'b1) acks++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL ovw_low: got %0d want 7", n); end
    n = 0;
    while (sig !== 1'b0 && n < 500) begin step(); n++; if (load_ack === 1'b1) acks++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL ovw_high: got %0d want 7", n); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL ovw_ack_count: got %0d want 1", acks); end
    stop_run();
    // Zero alone clamps to one: period 2.
    half_period = 0; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL clamp_ack: got %b want 1", load_ack); end
    step();
    start_run();
    cycles_until(1'b1, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL clamp_rise: got %0d want 1", n); end
    cycles_until(1'b0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL clamp_high: got %0d want 1", n); end
    cycles_until(1'b1, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL clamp_low: got %0d want 1", n); end
    stop_run();
  endtask

  task automatic test_boundary_load();
    int n;
    load_idle(3);
    start_run();
    cycles_until(1'b1, n);
    step();
    step();
    half_period = 2; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (sig !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL bnd_fall: got sig=%b ack=%b want 0 0", sig, load_ack); end
    cycles_until(1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL bnd_old_low: got %0d want 3", n); end
    cycles_until(1'b0, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL bnd_old_high: got %0d want 3", n); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL bnd_ack: got %b want 1", load_ack); end
    step();
    cycles_until(1'b1, n);
    checks++; if (n + 1 !== 2) begin errors++; $display("FAIL bnd_new_low: got %0d want 2", n + 1); end
    stop_run();
  endtask

  task automatic test_stop_pending();
    int n;
    load_idle(6);
    start_run();
    step();
    step();
    half_period = 4; load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL stp_pending_ack: got %b want 0", load_ack); end
    en = 1'b0;
    step();
    checks++; if (sig !== 1'b0 || running !== 1'b0 || load_ack !== 1'b1) begin errors++; $display("FAIL stp_apply: got sig=%b run=%b ack=%b want 0 0 1", sig, running, load_ack); end
    step();
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL stp_ack_pulse: got %b want 0", load_ack); end
    start_run();
    cycles_until(1'b1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL stp_new_rise: got %0d want 4", n); end
    stop_run();
  endtask

  task automatic test_midrun_reset();
    int n;
    load_idle(2);
    start_run();
    cycles_until(1'b1, n);
    half_period = 9; load = 1'b1;
    step();
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sig !== 1'b0 || running !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL async_reset: got sig=%b run=%b ack=%b want 0 0 0", sig, running, load_ack); end
    en = 1'b0;
    #2 rst_n = 1'b1;
    step();
    start_run();
    cycles_until(1'b1, n);
    checks++; if (n !== 50) begin errors++; $display("FAIL reset_default_restored: got %0d want 50", n); end
    stop_run();
  endtask

`ifdef FREQ_GEN_BURST_EN
  task automatic test_burst();
    int rises;
    int falls;
    int third_fall;
    int done_at;
    logic prev;
    burst_len = 16'd3;
    load_idle(4);
    en = 1'b1;
    rises = 0; falls = 0; third_fall = -1; done_at = -1; prev = sig;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (!prev && sig) rises++;
      if (prev && !sig) begin falls++; if (falls == 3) third_fall = i; end
      if (burst_done === 1'b1 && done_at < 0) done_at = i;
      prev = sig;
    end
    checks++; if (rises !== 3) begin errors++; $display("FAIL burst_rises: got %0d want 3", rises); end
    checks++; if (third_fall !== 25) begin errors++; $display("FAIL burst_third_fall: got %0d want 25", third_fall); end
    checks++; if (done_at !== 25) begin errors++; $display("FAIL burst_done_time: got %0d want 25", done_at); end
    checks++; if (burst_done !== 1'b1 || sig !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL burst_hold: got done=%b sig=%b run=%b want 1 0 0", burst_done, sig, running); end
    en = 1'b0;
    step();
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL burst_clear: got %b want 0", burst_done); end
    burst_len = 16'd0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_load_idle();
    test_live_change();
    test_clamp_overwrite();
    test_boundary_load();
    test_stop_pending();
    test_midrun_reset();
`ifdef FREQ_GEN_BURST_EN
    test_burst();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
